player_move_arbiter: RTL and testbench

- Per-frame scheduler sharing the gate resource (x window GATE_LEFT..GATE_RIGHT, opened by button_pressed) between two player datapaths.
- Decides once per frame, on the v_tick rising edge, whether each player takes a one-pixel step and in which direction.
- Emits single-cycle step pulses to the player position registers.
- Grants gate ownership to at most one player, with round-robin fairness on contention.

---
 rtl/state_pkg.sv | 22 ++
 rtl/move_eval.sv | 53 +++++
 rtl/player_move_arbiter.sv | 130 +++++++++++++
 tb/tb_player_move_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/state_pkg.sv
// Shared types and defaults for the player move arbiter: FSM states,
// gate-owner encodings and playfield geometry.
package state_pkg;

  localparam int XW = 12;

  localparam int GATE_LEFT_DEFAULT  = 350;
  localparam int GATE_RIGHT_DEFAULT = 450;
  localparam int X_MAX_DEFAULT      = 760;

  typedef enum logic [1:0] {
    IDLE,
    EVAL_P1,
    EVAL_P2,
    ISSUE
  } ArbState;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_P1   = 2'b01;
  localparam logic [1:0] OWN_P2   = 2'b10;

endpackage

// File: rtl/move_eval.sv
// Combinational per-player step decision: request decode, bounds check and
// gate entry/exit rules for a single player.
module move_eval
  import state_pkg::*;
#(
  parameter int GATE_LEFT  = GATE_LEFT_DEFAULT,
  parameter int GATE_RIGHT = GATE_RIGHT_DEFAULT,
  parameter int X_MAX      = X_MAX_DEFAULT
) (
  input  logic [XW-1:0] x,
  input  logic          req_right,
  input  logic          req_left,
  input  logic          button_pressed,
  input  logic          owned,
  input  logic          gate_free,
  output logic          grant,
  output logic          dir,
  output logic          wants_entry,
  output logic          is_inside
);

  localparam logic [XW-1:0] GL_V   = XW'(GATE_LEFT);
  localparam logic [XW-1:0] GR_V   = XW'(GATE_RIGHT);
  localparam logic [XW-1:0] XMAX_V = XW'(X_MAX);
  localparam logic [XW-1:0] ONE    = XW'(1);

  logic          go_right;
  logic          go_left;
  logic          bound_ok;
  logic          target_inside;
  logic [XW-1:0] target;

  // The target may wrap when bound_ok is low; it is never used in that case.
  always_comb begin
    go_right      = req_right & ~req_left;
    go_left       = req_left & ~req_right;
    bound_ok      = (go_right && (x < XMAX_V)) || (go_left && (x != '0));
    target        = go_right ? (x + ONE) : (x - ONE);
    is_inside     = (x >= GL_V) && (x <= GR_V);
    target_inside = (target >= GL_V) && (target <= GR_V);
    wants_entry   = bound_ok & ~is_inside & target_inside;
    dir           = go_right;
    grant         = 1'b0;
    case ({is_inside, target_inside})
      2'b00: grant = bound_ok;
      2'b01: grant = bound_ok & button_pressed & (owned | gate_free);
      2'b11: grant = bound_ok & button_pressed & owned;
      2'b10: grant = bound_ok;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/player_move_arbiter.sv
// Per-frame scheduler: on each v_tick rising edge evaluates both players in
// turn, resolves gate contention round-robin and issues one-cycle step pulses.
module player_move_arbiter
  import state_pkg::*;
#(
  parameter int GATE_LEFT  = GATE_LEFT_DEFAULT,
  parameter int GATE_RIGHT = GATE_RIGHT_DEFAULT,
  parameter int X_MAX      = X_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          v_tick,
  input  logic [1:0]    req_right,
  input  logic [1:0]    req_left,
  input  logic          button_pressed,
  input  logic [XW-1:0] xpos_p1,
  input  logic [XW-1:0] xpos_p2,
  output logic          step_p1,
  output logic          dir_p1,
  output logic          step_p2,
  output logic          dir_p2,
  output logic [1:0]    gate_owner,
  output logic          busy,
  output logic          overrun
);

  ArbState    state;
  logic       v_tick_old;
  logic       rr;
  logic       rise;
  logic [1:0] owner_eff;
  logic       p1_grant_q, p1_dir_q, p1_entry_q;
  logic       grant1, dir1, entry1, inside1;
  logic       grant2, dir2, entry2, inside2;
  logic       contention, p1_win, p2_win;

  assign rise = v_tick & ~v_tick_old;

  // An owner standing outside the zone has left it; treat the gate as free.
  always_comb begin
    owner_eff = gate_owner;
    if ((gate_owner == OWN_P1 && !inside1) || (gate_owner == OWN_P2 && !inside2))
      owner_eff = OWN_NONE;
  end

  move_eval #(.GATE_LEFT(GATE_LEFT), .GATE_RIGHT(GATE_RIGHT), .X_MAX(X_MAX)) u_eval_p1 (
    .x(xpos_p1), .req_right(req_right[0]), .req_left(req_left[0]),
    .button_pressed(button_pressed), .owned(owner_eff == OWN_P1),
    .gate_free(owner_eff == OWN_NONE), .grant(grant1), .dir(dir1),
    .wants_entry(entry1), .is_inside(inside1)
  );

  move_eval #(.GATE_LEFT(GATE_LEFT), .GATE_RIGHT(GATE_RIGHT), .X_MAX(X_MAX)) u_eval_p2 (
    .x(xpos_p2), .req_right(req_right[1]), .req_left(req_left[1]),
    .button_pressed(button_pressed), .owned(owner_eff == OWN_P2),
    .gate_free(owner_eff == OWN_NONE), .grant(grant2), .dir(dir2),
    .wants_entry(entry2), .is_inside(inside2)
  );

  // Ownership is only taken at ISSUE, so both players can see a free gate in
  // the same frame; rr picks the winner (0 = P1).
  always_comb begin
    contention = p1_entry_q & grant2 & entry2;
    p1_win     = p1_grant_q & ~(contention & rr);
    p2_win     = grant2 & ~(contention & ~rr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      v_tick_old <= 1'b0;
      rr         <= 1'b0;
      step_p1    <= 1'b0;
      dir_p1     <= 1'b0;
      step_p2    <= 1'b0;
      dir_p2     <= 1'b0;
      gate_owner <= OWN_NONE;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      p1_grant_q <= 1'b0;
      p1_dir_q   <= 1'b0;
      p1_entry_q <= 1'b0;
    end else begin
      v_tick_old <= v_tick;
      step_p1    <= 1'b0;
      step_p2    <= 1'b0;
      if (rise && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= EVAL_P1;
            busy  <= 1'b1;
          end
        end
        EVAL_P1: begin
          gate_owner <= owner_eff;
          p1_grant_q <= grant1;
          p1_dir_q   <= dir1;
          p1_entry_q <= grant1 & entry1;
          state      <= EVAL_P2;
        end
        EVAL_P2: begin
          step_p1 <= p1_win;
          step_p2 <= p2_win;
          if (p1_win) dir_p1 <= p1_dir_q;
          if (p2_win) dir_p2 <= dir2;
          if (p1_win && p1_entry_q)
            gate_owner <= OWN_P1;
          else if (p2_win && entry2)
            gate_owner <= OWN_P2;
          else
            gate_owner <= owner_eff;
          if (contention)
            rr <= ~rr;
          state <= ISSUE;
        end
        ISSUE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_arbiter.sv
// Scoreboard bench: each frame pushes its expected outcome; a monitor pops and
// compares when the DUT finishes a frame (busy falls after the ISSUE cycle).
module tb_player_move_arbiter;

  typedef struct {
    logic       s1;
    logic       d1;
    logic       s2;
    logic       d2;
    logic [1:0] own;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_tick = 1'b0;
  logic [1:0]  req_right = '0;
  logic [1:0]  req_left = '0;
  logic        button_pressed = 1'b0;
  logic [11:0] xpos_p1 = '0;
  logic [11:0] xpos_p2 = '0;
  logic        step_p1, dir_p1, step_p2, dir_p2, busy, overrun;
  logic [1:0]  gate_owner;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  logic cap_s1, cap_d1, cap_s2, cap_d2;

  player_move_arbiter dut (
    .clk(clk), .rst(rst), .v_tick(v_tick), .req_right(req_right),
    .req_left(req_left), .button_pressed(button_pressed),
    .xpos_p1(xpos_p1), .xpos_p2(xpos_p2), .step_p1(step_p1), .dir_p1(dir_p1),
    .step_p2(step_p2), .dir_p2(dir_p2), .gate_owner(gate_owner),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ISSUE is the third busy cycle; a step anywhere else is a timing error.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      if (step_p1 || step_p2) checkOutput("step_in_reset", {10'd0, step_p2, step_p1}, 12'd0);
    end else begin
      if (busy) begin
        busy_cnt++;
        if (busy_cnt == 3) begin
          cap_s1 = step_p1; cap_d1 = dir_p1; cap_s2 = step_p2; cap_d2 = dir_p2;
        end
      end else begin
        if (busy_cnt > 0) checkOutput("busy_len", 12'(busy_cnt), 12'd3);
        if (busy_cnt >= 3) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_frame", 12'd1, 12'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("step_p1", {11'd0, cap_s1}, {11'd0, e.s1});
            checkOutput("step_p2", {11'd0, cap_s2}, {11'd0, e.s2});
            if (e.s1) checkOutput("dir_p1", {11'd0, cap_d1}, {11'd0, e.d1});
            if (e.s2) checkOutput("dir_p2", {11'd0, cap_d2}, {11'd0, e.d2});
            checkOutput("gate_owner", {10'd0, gate_owner}, {10'd0, e.own});
          end
        end
        busy_cnt = 0;
      end
      if ((step_p1 || step_p2) && !(busy && busy_cnt == 3))
        checkOutput("step_timing", {10'd0, step_p2, step_p1}, 12'd0);
    end
  end

  task automatic drainWait();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("frame_timeout", 12'(sb.size()), 12'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] rright, input logic [1:0] rleft,
                               input logic btn, input int x1, input int x2,
                               input logic s1, input logic d1, input logic s2,
                               input logic d2, input logic [1:0] own);
    exp_t e;
    @(negedge clk);
    req_right = rright; req_left = rleft; button_pressed = btn;
    xpos_p1 = 12'(x1); xpos_p2 = 12'(x2);
    e.s1 = s1; e.d1 = d1; e.s2 = s2; e.d2 = d2; e.own = own;
    sb.push_back(e);
    v_tick = 1'b1;
    repeat (2) @(negedge clk);
    v_tick = 1'b0;
    drainWait();
  endtask

  initial begin
    // Reset held while v_tick toggles: nothing may start.
    repeat (4) begin
      @(negedge clk);
      v_tick = ~v_tick;
    end
    @(negedge clk);
    checkOutput("rst_step_p1", {11'd0, step_p1}, 12'd0);
    checkOutput("rst_dir_p1", {11'd0, dir_p1}, 12'd0);
    checkOutput("rst_step_p2", {11'd0, step_p2}, 12'd0);
    checkOutput("rst_dir_p2", {11'd0, dir_p2}, 12'd0);
    checkOutput("rst_owner", {10'd0, gate_owner}, 12'd0);
    checkOutput("rst_busy", {11'd0, busy}, 12'd0);
    checkOutput("rst_overrun", {11'd0, overrun}, 12'd0);
    v_tick = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    //            rright rleft  btn  x1   x2   s1 d1 s2 d2 own
    applyStimulus(2'b01, 2'b00, 0, 100, 600, 1, 1, 0, 0, 2'b00);
    applyStimulus(2'b01, 2'b00, 0, 349, 600, 0, 0, 0, 0, 2'b00);
    applyStimulus(2'b01, 2'b00, 1, 349, 600, 1, 1, 0, 0, 2'b01);
    applyStimulus(2'b10, 2'b00, 1, 350, 349, 0, 0, 0, 0, 2'b01);
    applyStimulus(2'b10, 2'b00, 1, 451, 349, 0, 0, 1, 1, 2'b10);
    applyStimulus(2'b00, 2'b00, 1, 451, 451, 0, 0, 0, 0, 2'b00);
    // Contention twice: P1 wins first, then P2.
    applyStimulus(2'b01, 2'b10, 1, 349, 451, 1, 1, 0, 0, 2'b01);
    applyStimulus(2'b00, 2'b00, 1, 451, 500, 0, 0, 0, 0, 2'b00);
    applyStimulus(2'b01, 2'b10, 1, 349, 451, 0, 0, 1, 0, 2'b10);
    applyStimulus(2'b00, 2'b00, 1, 100, 451, 0, 0, 0, 0, 2'b00);
    // Bounds and request decode.
    applyStimulus(2'b01, 2'b00, 0, 760, 600, 0, 0, 0, 0, 2'b00);
    applyStimulus(2'b00, 2'b01, 0, 0, 600, 0, 0, 0, 0, 2'b00);
    applyStimulus(2'b01, 2'b01, 0, 100, 600, 0, 0, 0, 0, 2'b00);
    applyStimulus(2'b10, 2'b01, 0, 100, 100, 1, 0, 1, 1, 2'b00);
    applyStimulus(2'b01, 2'b10, 0, 759, 1, 1, 1, 1, 0, 2'b00);
    // Owner frozen inside when the button drops.
    applyStimulus(2'b01, 2'b00, 1, 349, 600, 1, 1, 0, 0, 2'b01);
    applyStimulus(2'b01, 2'b00, 0, 350, 600, 0, 0, 0, 0, 2'b01);
    applyStimulus(2'b01, 2'b00, 1, 350, 600, 1, 1, 0, 0, 2'b01);
    applyStimulus(2'b00, 2'b00, 0, 451, 600, 0, 0, 0, 0, 2'b00);

    // Second rising edge two clocks after the first.
    checkOutput("overrun_before", {11'd0, overrun}, 12'd0);
    begin
      exp_t e;
      @(negedge clk);
      req_right = 2'b01; req_left = 2'b00; button_pressed = 1'b0;
      xpos_p1 = 12'd100; xpos_p2 = 12'd600;
      e.s1 = 1; e.d1 = 1; e.s2 = 0; e.d2 = 0; e.own = 2'b00;
      sb.push_back(e);
      v_tick = 1'b1;
      @(negedge clk); v_tick = 1'b0;
      @(negedge clk); v_tick = 1'b1;
      @(negedge clk); v_tick = 1'b0;
      drainWait();
    end
    checkOutput("overrun_set", {11'd0, overrun}, 12'd1);
    applyStimulus(2'b00, 2'b01, 0, 200, 600, 1, 0, 0, 0, 2'b00);
    checkOutput("overrun_sticky", {11'd0, overrun}, 12'd1);

    // Take the gate, then reset during EVAL_P2.
    applyStimulus(2'b01, 2'b00, 1, 349, 600, 1, 1, 0, 0, 2'b01);
    @(negedge clk);
    req_right = 2'b01; req_left = 2'b00; button_pressed = 1'b1;
    xpos_p1 = 12'd350;
    v_tick = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_step_p1", {11'd0, step_p1}, 12'd0);
    checkOutput("midrst_busy", {11'd0, busy}, 12'd0);
    checkOutput("midrst_owner", {10'd0, gate_owner}, 12'd0);
    checkOutput("midrst_overrun", {11'd0, overrun}, 12'd0);
    checkOutput("midrst_dir_p1", {11'd0, dir_p1}, 12'd0);
    v_tick = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_no_step", {10'd0, step_p2, step_p1}, 12'd0);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("post_rst_busy", {11'd0, busy}, 12'd0);
    checkOutput("sb_empty", 12'(sb.size()), 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
